// File: rtl/ook_burst_sequencer.sv
// OOK burst sequencer: FIFO-buffered payload bytes are serialised MSB-first at a programmable symbol
// period, and each burst is closed by a carrier-off guard gap. OOK_PREAMBLE_EN adds a PREAMBLE byte per burst.
module ook_burst_sequencer #(
  parameter int DEPTH    = 4,
  parameter int GAP_SYMS = 8
`ifdef OOK_PREAMBLE_EN
  ,
  parameter logic [7:0] PREAMBLE = 8'hAA
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [15:0]             sym_div,
  input  logic                    abort,
  output logic                    ook_data,
  output logic                    sym_strobe,
  output logic                    busy,
  output logic                    burst_done,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = $clog2(GAP_SYMS + 1);

`ifdef OOK_PREAMBLE_EN
  typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, GAP} state_t;
`endif

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          full;
  logic [7:0]    head;

  state_t        state, state_next;
  logic [15:0]   div, div_next;
  logic [15:0]   sym_cnt, sym_cnt_next;
  logic [2:0]    bit_cnt, bit_cnt_next;
  logic [GW-1:0] gap_cnt, gap_cnt_next;
  logic [7:0]    shift, shift_next;
  logic          ook_next;
  logic          strobe_next;
  logic          done_next;
  logic          more;

  assign full     = (fifo_count == CW'(DEPTH));
  assign in_ready = !full && !abort;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Abort flushes the FIFO by collapsing both pointers; storage contents are left stale.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      div        <= 16'd1;
      sym_cnt    <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      shift      <= '0;
      ook_data   <= 1'b0;
      sym_strobe <= 1'b0;
      busy       <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_next;
      div        <= div_next;
      sym_cnt    <= sym_cnt_next;
      bit_cnt    <= bit_cnt_next;
      gap_cnt    <= gap_cnt_next;
      shift      <= shift_next;
      ook_data   <= ook_next;
      sym_strobe <= strobe_next;
      busy       <= (state_next != IDLE);
      burst_done <= done_next;
    end
  end

  // Outputs are computed from the next-cycle view so every output leaves a flop in step with state.
  always_comb begin
    state_next   = state;
    div_next     = div;
    sym_cnt_next = sym_cnt;
    bit_cnt_next = bit_cnt;
    gap_cnt_next = gap_cnt;
    shift_next   = shift;
    ook_next     = ook_data;
    strobe_next  = 1'b0;
    done_next    = 1'b0;
    pop          = 1'b0;
    more         = (fifo_count != '0);
`ifdef OOK_PREAMBLE_EN
    if (state == PRE) begin
      more = 1'b1;
    end
`endif

    if (abort) begin
      state_next = IDLE;
      ook_next   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_count != '0) begin
            div_next     = (sym_div == 16'd0) ? 16'd1 : sym_div;
            sym_cnt_next = div_next - 16'd1;
            bit_cnt_next = 3'd0;
            strobe_next  = 1'b1;
`ifdef OOK_PREAMBLE_EN
            state_next   = PRE;
            shift_next   = PREAMBLE;
`else
            state_next   = DATA;
            shift_next   = head;
            pop          = 1'b1;
`endif
            ook_next     = shift_next[7];
          end
        end

`ifdef OOK_PREAMBLE_EN
        PRE,
`endif
        DATA: begin
          if (sym_cnt != 16'd0) begin
            sym_cnt_next = sym_cnt - 16'd1;
          end else begin
            sym_cnt_next = div - 16'd1;
            strobe_next  = 1'b1;
            if (bit_cnt != 3'd7) begin
              bit_cnt_next = bit_cnt + 3'd1;
              shift_next   = {shift[6:0], 1'b0};
            end else if (more) begin
              bit_cnt_next = 3'd0;
              shift_next   = head;
              pop          = 1'b1;
              state_next   = DATA;
            end else begin
              shift_next   = '0;
              gap_cnt_next = GW'(GAP_SYMS - 1);
              state_next   = GAP;
            end
            ook_next = shift_next[7];
          end
        end

        // Guard gap: carrier stays off; gap_cnt holds the number of gap symbols still to come.
        GAP: begin
          ook_next = 1'b0;
          if (sym_cnt != 16'd0) begin
            sym_cnt_next = sym_cnt - 16'd1;
          end else if (gap_cnt != '0) begin
            gap_cnt_next = gap_cnt - 1'b1;
            sym_cnt_next = div - 16'd1;
            strobe_next  = 1'b1;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end

        default: begin
          state_next = IDLE;
          ook_next   = 1'b0;
        end
      endcase
    end
  end

endmodule
